// File: rtl/spi_master.sv
// SPI mode-0 master: one 8-bit MSB-first transfer per start. Done arrives 1+18*HALF_DIV cycles after accept.
// There is no backpressure: start is only sampled in IDLE, so it is ignored while busy.
module spi_master #(
  parameter int HALF_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       miso,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;

  localparam logic [7:0] CNT_LAST = 8'(HALF_DIV - 1);

  state_e     state_q;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] edge_q;
  logic [7:0] tx_q, shift_q, rx_q;
  logic       sclk_q, cs_q, mosi_q, busy_q, done_q;
  logic       half_end;

  assign half_end = (cnt_q == CNT_LAST);
  assign cnt_d    = half_end ? 8'd0 : cnt_q + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 4'd0;
      tx_q    <= 8'd0;
      shift_q <= 8'd0;
      rx_q    <= 8'd0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_d;
      case (state_q)
        IDLE: begin
          cnt_q <= 8'd0;
          if (start) begin
            tx_q    <= tx_data;
            mosi_q  <= tx_data[7];
            cs_q    <= 1'b0;
            busy_q  <= 1'b1;
            edge_q  <= 4'd0;
            state_q <= LEAD;
          end
        end
        LEAD: begin
          if (half_end) state_q <= XFER;
        end
        XFER: begin
          // Every state change happens on half_end, so the counter wrap doubles as its reload.
          if (half_end) begin
            sclk_q <= ~sclk_q;
            edge_q <= edge_q + 4'd1;
            if (!sclk_q) begin
              shift_q <= {shift_q[6:0], miso};
            end else if (edge_q != 4'd15) begin
              tx_q   <= {tx_q[6:0], 1'b0};
              mosi_q <= tx_q[6];
            end
            if (edge_q == 4'd15) state_q <= TRAIL;
          end
        end
        TRAIL: begin
          if (half_end) begin
            state_q <= IDLE;
            cs_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rx_q    <= shift_q;
            mosi_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sclk    = sclk_q;
  assign cs      = cs_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: HALF_DIV=4 and HALF_DIV=2 instances share stimulus and are checked against
// a timeline model every cycle, plus literal expectations for latency, edges and received bytes.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [1:0] miso_w = 2'b00;
  logic [1:0] sclk_w, cs_w, mosi_w, busy_w, done_w;
  logic [1:0][7:0] rx_w;

  logic       loop_en = 1'b1;
  logic [7:0] sbyte = 8'h00;
  int sidx[2] = '{0, 0};
  logic sprev[2] = '{1'b0, 1'b0};

  int checks = 0;
  int errors = 0;

  // Model state: cycle index since accept, plus expected registered outputs.
  logic       m_busy[2] = '{1'b0, 1'b0};
  logic       m_done[2] = '{1'b0, 1'b0};
  int         m_k[2] = '{0, 0};
  logic [7:0] m_tx[2] = '{8'h00, 8'h00};
  logic [7:0] m_exp[2] = '{8'h00, 8'h00};
  logic [7:0] m_rx[2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  spi_master #(.HALF_DIV(4)) u_h4 (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .miso(miso_w[0]),
    .sclk(sclk_w[0]), .cs(cs_w[0]), .mosi(mosi_w[0]), .rx_data(rx_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  spi_master #(.HALF_DIV(2)) u_h2 (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .miso(miso_w[1]),
    .sclk(sclk_w[1]), .cs(cs_w[1]), .mosi(mosi_w[1]), .rx_data(rx_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  function automatic int hd(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_busy[i] <= 1'b0;
        m_done[i] <= 1'b0;
        m_k[i]    <= 0;
        m_rx[i]   <= 8'h00;
      end else begin
        m_done[i] <= 1'b0;
        if (m_busy[i]) begin
          if (m_k[i] + 1 == 18 * hd(i)) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b1;
            m_rx[i]   <= m_exp[i];
          end else begin
            m_k[i] <= m_k[i] + 1;
          end
        end else if (start) begin
          m_busy[i] <= 1'b1;
          m_k[i]    <= 0;
          m_tx[i]   <= tx_data;
          m_exp[i]  <= loop_en ? tx_data : sbyte;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // One negedge: compare both instances with the model, then drive the slave's miso.
  task automatic tick();
    int h, k, p, j;
    logic e_sclk, e_mosi;
    logic [12:0] exp_v, act_v;
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        h = hd(i);
        k = m_k[i];
        e_sclk = m_busy[i] && (k >= h) && (k < 17 * h) && ((((k - h) / h) % 2) == 1);
        p = (k < h) ? 0 : (k - h) / h;
        j = (p / 2 > 7) ? 7 : p / 2;
        e_mosi = m_busy[i] ? m_tx[i][7 - j] : 1'b0;
        exp_v = {~m_busy[i], m_busy[i], e_sclk, e_mosi, m_done[i], m_rx[i]};
        act_v = {cs_w[i], busy_w[i], sclk_w[i], mosi_w[i], done_w[i], rx_w[i]};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL cycle_model inst%0d t=%0t {cs,busy,sclk,mosi,done,rx} got %h expected %h",
                   i, $time, act_v, exp_v);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i]) sidx[i] = 0;
      else if (sprev[i] && !sclk_w[i]) sidx[i] = sidx[i] + 1;
      sprev[i] = sclk_w[i];
      miso_w[i] = loop_en ? mosi_w[i] : ((sidx[i] < 8) ? sbyte[7 - sidx[i]] : 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_cs%0d", nm, i), int'(cs_w[i]), 1);
      chk($sformatf("%s_sclk%0d", nm, i), int'(sclk_w[i]), 0);
      chk($sformatf("%s_mosi%0d", nm, i), int'(mosi_w[i]), 0);
      chk($sformatf("%s_rx%0d", nm, i), int'(rx_w[i]), 0);
      chk($sformatf("%s_busy%0d", nm, i), int'(busy_w[i]), 0);
      chk($sformatf("%s_done%0d", nm, i), int'(done_w[i]), 0);
    end
  endtask

  // Single transfer; caller is just after a negedge. Latencies and edge counts are literals.
  task automatic xfer(input string nm, input logic [7:0] tx, input logic [7:0] exp_rx);
    int dcyc[2] = '{-1, -1};
    int csl[2] = '{0, 0};
    int rise[2] = '{0, 0};
    logic ps[2] = '{1'b0, 1'b0};
    logic [7:0] mseq = 8'h00;
    start = 1'b1;
    tx_data = tx;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) begin
        start = 1'b0;
        tx_data = ~tx;
      end
      for (int i = 0; i < 2; i++) begin
        if (!cs_w[i]) csl[i]++;
        if (sclk_w[i] && !ps[i]) begin
          rise[i]++;
          if (i == 0) mseq = {mseq[6:0], mosi_w[0]};
        end
        ps[i] = sclk_w[i];
        if (done_w[i] && dcyc[i] < 0) dcyc[i] = n;
      end
      if (dcyc[0] >= 0 && dcyc[1] >= 0) break;
    end
    chk({nm, "_done_cyc_h4"}, dcyc[0], 73);
    chk({nm, "_done_cyc_h2"}, dcyc[1], 37);
    chk({nm, "_cs_low_h4"}, csl[0], 72);
    chk({nm, "_cs_low_h2"}, csl[1], 36);
    chk({nm, "_rises_h4"}, rise[0], 8);
    chk({nm, "_rises_h2"}, rise[1], 8);
    chk({nm, "_mosi_seq"}, int'(mseq), int'(tx));
    chk({nm, "_rx_h4"}, int'(rx_w[0]), int'(exp_rx));
    chk({nm, "_rx_h2"}, int'(rx_w[1]), int'(exp_rx));
  endtask

  initial begin
    int ndone[2];
    int gap[2];
    int seen_first[2];
    bit dropped;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    repeat (3) tick();

    loop_en = 1'b1;
    xfer("loop_a5", 8'hA5, 8'hA5);
    repeat (3) tick();

    loop_en = 1'b0;
    sbyte = 8'h3C;
    xfer("slave_3c", 8'h96, 8'h3C);
    repeat (3) tick();

    // Reset 30 cycles into a transfer: everything drops at once, rx_data is cleared.
    loop_en = 1'b1;
    start = 1'b1;
    tx_data = 8'hC3;
    tick();
    start = 1'b0;
    repeat (29) tick();
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();
    xfer("after_rst_81", 8'h81, 8'h81);
    repeat (3) tick();

    // start held high: FF then 00 back to back, cs high for one cycle between them.
    ndone = '{0, 0};
    gap = '{0, 0};
    seen_first = '{0, 0};
    dropped = 1'b0;
    start = 1'b1;
    tx_data = 8'hFF;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (n == 1) tx_data = 8'h00;
      for (int i = 0; i < 2; i++) begin
        if (done_w[i]) begin
          ndone[i]++;
          if (ndone[i] == 1) seen_first[i] = 1;
        end
        if (seen_first[i] == 1) begin
          if (cs_w[i]) gap[i]++;
          else seen_first[i] = 2;
        end
      end
      if (!dropped && ndone[0] == 1 && !cs_w[0]) begin
        start = 1'b0;
        dropped = 1'b1;
      end
      if (ndone[0] == 2) break;
    end
    repeat (10) tick();
    chk("b2b_dones_h4", ndone[0], 2);
    chk("b2b_dones_h2", ndone[1], 2);
    chk("b2b_gap_h4", gap[0], 1);
    chk("b2b_gap_h2", gap[1], 1);
    chk("b2b_rx_h4", int'(rx_w[0]), 8'h00);
    chk("b2b_rx_h2", int'(rx_w[1]), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
